hs_slave_fifo: RTL and testbench
================================

# hs_slave_fifo

Receiving end of the 32-bit valid/ready handshake link: accepts beats from a handshake master, buffers them in a small FIFO, and re-presents them on a downstream valid/ready port. It reports every accepted beat with `data_success`, exposes occupancy, and flags upstream protocol violations. It is a drop-in replacement for the simple slave in the master/slave handshake benches, and it tolerates transport delay on `valid` and `ready`.

## Interface
- `DATA_W`, 32, width of the data bus.
- `DEPTH`, 4, FIFO depth in beats; must be a power of two, ≥ 2.
- `CNT_W`, $clog2(DEPTH)+1, width of the occupancy count.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  DATA_W  upstream payload.
- `valid`  in  1  upstream beat valid.
- `ready`  out  1  upstream ready; high when the FIFO is not full.
- `data_success`  out  1  one-cycle pulse per accepted upstream beat.
- `m_data`  out  DATA_W  downstream payload (FIFO head).
- `m_valid`  out  1  downstream valid; high when the FIFO is not empty.
- `m_ready`  in  1  downstream ready.
- `count`  out  CNT_W  current number of stored beats.
- `proto_err`  out  1  sticky upstream protocol-violation flag.

## Operation
- Push: a push occurs at a rising edge when `valid && ready`. It writes `data` to `mem[wr_ptr]` and increments `wr_ptr` modulo DEPTH.
- Pop: a pop occurs at a rising edge when `m_valid && m_ready`. It increments `rd_ptr` modulo DEPTH.
- `m_data` = `mem[rd_ptr]`, read combinationally from the array. Its value is don't-care while `m_valid`=0.
- `count`: incremented on push only, decremented on pop only, unchanged when both or neither occur.
- `ready` = (`count` != DEPTH) and `m_valid` = (`count` != 0). Both are decoded from registered state only; there is no combinational path from `valid` or `m_ready`.
- Full with `m_ready`=1: `ready` is still 0 during that cycle. No push is taken, the pop proceeds, and `ready` rises in the next cycle.
- Empty: no bypass. A beat pushed into an empty FIFO is not visible downstream in the same cycle.
- Protocol checker: registers `valid`, `ready` and `data` each cycle.
  - If the previous cycle was a stall (`valid`=1, `ready`=0), then in the current cycle `valid`=0 or `data` differing from the registered value is a violation.
  - A violation sets `proto_err` at the next edge.
  - `proto_err` stays set until reset.
  - A violation does not block or alter FIFO operation.
- `data_success`: registered. It is high for exactly the one cycle following each push edge. On back-to-back pushes it stays high continuously.

## Timing
- Reset (`rst_n`=0, asynchronous): `wr_ptr`=`rd_ptr`=0, `count`=0, `ready`=1, `m_valid`=0, `data_success`=0, `proto_err`=0. Checker history is cleared (previous stall = 0). Memory contents are not reset.
- Reset mid-operation: all buffered beats are discarded. Outputs take their reset values immediately, without waiting for a clock edge.
- Latency: a beat pushed at edge N drives `m_valid`=1 and `m_data`=beat from just after edge N. The earliest pop is at edge N+1. `data_success` is high from N to N+1.
- Throughput: one push and one pop per cycle, sustained while 0 < `count` < DEPTH.
- Recovery from full: `ready` returns to 1 in the cycle after the first pop from full.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Order is preserved across the wrap.

## Test plan
- Reset: hold `rst_n`=0 with `valid`=1 -> `ready`=1, `m_valid`=0, `count`=0, `data_success`=0, `proto_err`=0; no push occurs.
- Single beat: `valid`=1 with `data`=32'hA5A5_0001 for one cycle, `m_ready`=0 -> next cycle `count`=1, `m_valid`=1, `m_data`=32'hA5A5_0001, one `data_success` pulse.
- Fill: push 1,2,3,4 with `m_ready`=0 -> `count`=4, `ready`=0; a 5th beat is held without loss. Raise `m_ready` -> outputs 1,2,3,4 in order, then the 5th beat is accepted after `ready` returns to 1.
- Simultaneous push and pop: with `count`=2, `valid`=1 and `m_ready`=1 for 6 cycles -> `count` stays 2 and data is in order through pointer wrap-around.
- Protocol violation: stall with `count`=4, then change `data` from 32'h1 to 32'h2 while `valid`=1 -> `proto_err`=1 after the next edge, and it stays set until `rst_n` pulses low.
- Reset mid-stream: assert `rst_n`=0 asynchronously with `count`=3 -> `count`=0, `m_valid`=0 and `ready`=1 immediately; after release, the next pushed beat appears first on `m_data`.

Source files
------------

// File: rtl/hs_slave_fifo.sv
// hs_slave_fifo: valid/ready receiver with a small FIFO,
// occupancy count, accept pulse and sticky protocol checker.
module hs_slave_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              data_success,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  count,
  output logic              proto_err
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic              violation;

  assign ready   = (count != CNT_W'(DEPTH));
  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];

  assign push = valid && ready;
  assign pop  = m_valid && m_ready;

  assign violation = prev_stall &&
                     (!valid || (data != prev_data));

  // Storage is left unreset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_success <= 1'b0;
    end else begin
      data_success <= push;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_data  <= '0;
      proto_err  <= 1'b0;
    end else begin
      prev_stall <= valid && !ready;
      prev_data  <= data;
      if (violation) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_slave_fifo.sv
// tb_hs_slave_fifo: table-driven vectors plus hand
// sequences for reset, protocol error and async reset.
module tb_hs_slave_fifo;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        data_success;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  count;
  logic        proto_err;

  int errors;
  int checks;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        mr;
    logic        rdy;
    logic        mv;
    logic [2:0]  cnt;
    logic [31:0] md;
    logic        ds;
    logic        pe;
  } vec_t;

  vec_t vq[$];

  hs_slave_fifo #(
    .DATA_W(32),
    .DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .valid(valid),
    .ready(ready),
    .data_success(data_success),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .count(count),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag,
                          input logic rdy,
                          input logic mv,
                          input logic [2:0] cnt,
                          input logic [31:0] md,
                          input logic ds,
                          input logic pe);
    chk({tag, " ready"}, 32'(ready), 32'(rdy));
    chk({tag, " m_valid"}, 32'(m_valid), 32'(mv));
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " data_success"}, 32'(data_success), 32'(ds));
    chk({tag, " proto_err"}, 32'(proto_err), 32'(pe));
    if (mv) begin
      chk({tag, " m_data"}, m_data, md);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d,
                     input logic mr, input logic rdy,
                     input logic mv, input logic [2:0] cnt,
                     input logic [31:0] md, input logic ds,
                     input logic pe);
    vq.push_back('{v, d, mr, rdy, mv, cnt, md, ds, pe});
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    valid   = 1'b1;
    data    = 32'hDEAD_BEEF;
    m_ready = 1'b0;

    // single beat and drain
    add(1, 32'hA5A5_0001, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 32'hA5A5_0001, 1, 0);
    add(0, 0, 0, 1, 1, 1, 32'hA5A5_0001, 0, 0);
    add(0, 0, 1, 1, 1, 1, 32'hA5A5_0001, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // fill, hold 5th, drain
    add(1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 1, 1, 1, 1, 0);
    add(1, 3, 0, 1, 1, 2, 1, 1, 0);
    add(1, 4, 0, 1, 1, 3, 1, 1, 0);
    add(1, 5, 0, 0, 1, 4, 1, 1, 0);
    add(1, 5, 0, 0, 1, 4, 1, 0, 0);
    add(1, 5, 1, 0, 1, 4, 1, 0, 0);
    add(1, 5, 1, 1, 1, 3, 2, 0, 0);
    add(0, 0, 1, 1, 1, 3, 3, 1, 0);
    add(0, 0, 1, 1, 1, 2, 4, 0, 0);
    add(0, 0, 1, 1, 1, 1, 5, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // simultaneous push/pop across pointer wrap
    add(1, 32'h10, 0, 1, 0, 0, 0, 0, 0);
    add(1, 32'h11, 0, 1, 1, 1, 32'h10, 1, 0);
    add(1, 32'h12, 1, 1, 1, 2, 32'h10, 1, 0);
    add(1, 32'h13, 1, 1, 1, 2, 32'h11, 1, 0);
    add(1, 32'h14, 1, 1, 1, 2, 32'h12, 1, 0);
    add(1, 32'h15, 1, 1, 1, 2, 32'h13, 1, 0);
    add(1, 32'h16, 1, 1, 1, 2, 32'h14, 1, 0);
    add(1, 32'h17, 1, 1, 1, 2, 32'h15, 1, 0);
    add(0, 0, 1, 1, 1, 2, 32'h16, 1, 0);
    add(0, 0, 1, 1, 1, 1, 32'h17, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // fill, stall, then change data while stalled
    add(1, 32'h20, 0, 1, 0, 0, 0, 0, 0);
    add(1, 32'h21, 0, 1, 1, 1, 32'h20, 1, 0);
    add(1, 32'h22, 0, 1, 1, 2, 32'h20, 1, 0);
    add(1, 32'h23, 0, 1, 1, 3, 32'h20, 1, 0);
    add(1, 32'h1, 0, 0, 1, 4, 32'h20, 1, 0);
    add(1, 32'h2, 0, 0, 1, 4, 32'h20, 0, 0);
    add(1, 32'h2, 0, 0, 1, 4, 32'h20, 0, 1);
    add(0, 0, 0, 0, 1, 4, 32'h20, 0, 1);
    add(0, 0, 0, 0, 1, 4, 32'h20, 0, 1);

    // reset held with valid high: no push
    #2;
    chk_outs("rst", 1, 0, 0, 0, 0, 0);
    next_edge();
    next_edge();
    chk_outs("rst_hold", 1, 0, 0, 0, 0, 0);
    valid = 1'b0;
    #2;
    rst_n = 1'b1;
    next_edge();

    foreach (vq[i]) begin
      valid   = vq[i].v;
      data    = vq[i].d;
      m_ready = vq[i].mr;
      #2;
      chk_outs($sformatf("vec%0d", i), vq[i].rdy,
               vq[i].mv, vq[i].cnt, vq[i].md,
               vq[i].ds, vq[i].pe);
      next_edge();
    end

    // pop once: count 3, error still sticky
    m_ready = 1'b1;
    next_edge();
    m_ready = 1'b0;
    #2;
    chk_outs("pop3", 1, 1, 3, 32'h21, 0, 1);

    // asynchronous reset mid-cycle with count 3
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    next_edge();
    chk_outs("post_rst", 1, 0, 0, 0, 0, 0);

    valid = 1'b1;
    data  = 32'hBEEF_0042;
    next_edge();
    valid = 1'b0;
    data  = 32'h0;
    #2;
    chk_outs("first_after_rst", 1, 1, 1,
             32'hBEEF_0042, 1, 0);
    next_edge();
    chk_outs("hold_after_rst", 1, 1, 1,
             32'hBEEF_0042, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
